// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection front end: pedestrian FSM state
// encoding and the default timing constants.
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SERVING = 2'd2,
    HOLDOFF = 2'd3
  } ped_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_HOLDOFF_TICKS   = 5;
  localparam int DEF_MAX_WAIT_TICKS  = 30;

endpackage

// File: rtl/ped_req_channel.sv
// One pedestrian channel: button synchroniser and debounce, walk-light
// synchroniser, and the request/serve/hold-off state machine.
module ped_req_channel
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLDOFF_TICKS   = DEF_HOLDOFF_TICKS,
  parameter int MAX_WAIT_TICKS  = DEF_MAX_WAIT_TICKS
) (
  input  logic clk_50_mhz,
  input  logic reset_n,
  input  logic i_button_n,
  input  logic i_tick_1hz,
  input  logic i_walk_active,
  output logic o_xwalk_req,
  output logic o_xwalk_urgent
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int WT_W = $clog2(MAX_WAIT_TICKS) + 1;
  localparam int HO_W = $clog2(HOLDOFF_TICKS) + 1;
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WT_W-1:0] WAIT_MAX  = WT_W'(MAX_WAIT_TICKS);
  localparam logic [HO_W-1:0] HOLD_LOAD = HO_W'(HOLDOFF_TICKS);

  logic            r_btn_s1, r_btn_s2;
  logic            r_db_lvl, r_db_lvl_d;
  logic [DB_W-1:0] r_db_cnt;
  logic            r_walk_s1, r_walk_s2;
  ped_state_t      r_state, w_state_nx;
  logic [WT_W-1:0] r_wait_cnt, w_wait_nx;
  logic [HO_W-1:0] r_hold_cnt, w_hold_nx;
  logic            w_press;

  // Button is inverted on entry so every internal level reads 1 = pressed.
  always_ff @(posedge clk_50_mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_btn_s1   <= 1'b0;
      r_btn_s2   <= 1'b0;
      r_db_lvl   <= 1'b0;
      r_db_lvl_d <= 1'b0;
      r_db_cnt   <= '0;
      r_walk_s1  <= 1'b0;
      r_walk_s2  <= 1'b0;
    end else begin
      r_btn_s1   <= ~i_button_n;
      r_btn_s2   <= r_btn_s1;
      r_db_lvl_d <= r_db_lvl;
      r_walk_s1  <= i_walk_active;
      r_walk_s2  <= r_walk_s1;
      if (r_btn_s2 == r_db_lvl) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_db_lvl <= r_btn_s2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end
  end

  assign w_press = r_db_lvl & ~r_db_lvl_d;

  always_ff @(posedge clk_50_mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_wait_cnt <= w_wait_nx;
      r_hold_cnt <= w_hold_nx;
    end
  end

  // Presses outside IDLE are dropped, not queued.
  always_comb begin
    w_state_nx = r_state;
    w_wait_nx  = r_wait_cnt;
    w_hold_nx  = r_hold_cnt;
    case (r_state)
      IDLE: begin
        if (w_press) begin
          w_state_nx = PENDING;
          w_wait_nx  = '0;
        end
      end
      PENDING: begin
        if (r_walk_s2) begin
          w_state_nx = SERVING;
        end else if (i_tick_1hz && (r_wait_cnt != WAIT_MAX)) begin
          w_wait_nx = r_wait_cnt + WT_W'(1);
        end
      end
      SERVING: begin
        if (!r_walk_s2) begin
          w_state_nx = HOLDOFF;
          w_hold_nx  = HOLD_LOAD;
        end
      end
      HOLDOFF: begin
        if (i_tick_1hz) begin
          w_hold_nx = r_hold_cnt - HO_W'(1);
          if (r_hold_cnt == HO_W'(1)) w_state_nx = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign o_xwalk_req    = (r_state == PENDING);
  assign o_xwalk_urgent = (r_state == PENDING) && (r_wait_cnt == WAIT_MAX);

endmodule

// File: rtl/ped_request_latch.sv
// Two-channel pedestrian request front end; north and west channels are
// fully independent instances with no arbitration between them.
module ped_request_latch
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLDOFF_TICKS   = DEF_HOLDOFF_TICKS,
  parameter int MAX_WAIT_TICKS  = DEF_MAX_WAIT_TICKS
) (
  input  logic clk_50_mhz,
  input  logic reset_n,
  input  logic nrth_pedo_button,
  input  logic west_pedo_button,
  input  logic tick_1hz,
  input  logic nrth_walk_active,
  input  logic west_walk_active,
  output logic nrth_xwalk_req,
  output logic west_xwalk_req,
  output logic nrth_xwalk_urgent,
  output logic west_xwalk_urgent
);

  ped_req_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLDOFF_TICKS  (HOLDOFF_TICKS),
    .MAX_WAIT_TICKS (MAX_WAIT_TICKS)
  ) u_nrth (
    .clk_50_mhz    (clk_50_mhz),
    .reset_n       (reset_n),
    .i_button_n    (nrth_pedo_button),
    .i_tick_1hz    (tick_1hz),
    .i_walk_active (nrth_walk_active),
    .o_xwalk_req   (nrth_xwalk_req),
    .o_xwalk_urgent(nrth_xwalk_urgent)
  );

  ped_req_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLDOFF_TICKS  (HOLDOFF_TICKS),
    .MAX_WAIT_TICKS (MAX_WAIT_TICKS)
  ) u_west (
    .clk_50_mhz    (clk_50_mhz),
    .reset_n       (reset_n),
    .i_button_n    (west_pedo_button),
    .i_tick_1hz    (tick_1hz),
    .i_walk_active (west_walk_active),
    .o_xwalk_req   (west_xwalk_req),
    .o_xwalk_urgent(west_xwalk_urgent)
  );

endmodule

// File: tb/tb_ped_request_latch.sv
// Scoreboard bench for ped_request_latch: a request-level reference model
// predicts the four outputs every cycle; a monitor compares on falling edges.
module tb_ped_request_latch;

  localparam int DB = 4;
  localparam int HO = 2;
  localparam int MW = 3;
  localparam int TICK_PERIOD = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic nb = 1'b1, wb = 1'b1;
  logic tick = 1'b0;
  logic nwa = 1'b0, wwa = 1'b0;
  logic nreq, wreq, nurg, wurg;

  int vectors = 0;
  int miscompares = 0;
  int tcnt = 0;

  always #5 clk = ~clk;

  ped_request_latch #(
    .DEBOUNCE_CYCLES(DB),
    .HOLDOFF_TICKS  (HO),
    .MAX_WAIT_TICKS (MW)
  ) dut (
    .clk_50_mhz       (clk),
    .reset_n          (reset_n),
    .nrth_pedo_button (nb),
    .west_pedo_button (wb),
    .tick_1hz         (tick),
    .nrth_walk_active (nwa),
    .west_walk_active (wwa),
    .nrth_xwalk_req   (nreq),
    .west_xwalk_req   (wreq),
    .nrth_xwalk_urgent(nurg),
    .west_xwalk_urgent(wurg)
  );

  // Reference model: button samples reach the filter two edges late, a level
  // change needs DB consecutive differing samples, a rise becomes a press one
  // edge later; requests are tracked as pending / being served / hold-off left.
  logic [3:0] exp_q[$];
  int m_raw1[2], m_raw2[2], m_walk1[2], m_walk2[2];
  int m_lvl[2], m_run[2], m_rose[2];
  int m_pend[2], m_serv[2], m_hold[2], m_wait[2];
  int raw_now[2], walk_now[2];
  int press, wk, synced;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < 2; c++) begin
        m_raw1[c] = 0; m_raw2[c] = 0; m_walk1[c] = 0; m_walk2[c] = 0;
        m_lvl[c] = 0; m_run[c] = 0; m_rose[c] = 0;
        m_pend[c] = 0; m_serv[c] = 0; m_hold[c] = 0; m_wait[c] = 0;
      end
      exp_q.delete();
    end else begin
      raw_now[0] = (nb == 1'b0) ? 1 : 0;
      raw_now[1] = (wb == 1'b0) ? 1 : 0;
      walk_now[0] = (nwa == 1'b1) ? 1 : 0;
      walk_now[1] = (wwa == 1'b1) ? 1 : 0;
      for (int c = 0; c < 2; c++) begin
        press  = m_rose[c];
        wk     = m_walk2[c];
        synced = m_raw2[c];
        if (m_pend[c] != 0) begin
          if (wk != 0) begin
            m_pend[c] = 0;
            m_serv[c] = 1;
          end else if (tick && m_wait[c] < MW) begin
            m_wait[c] = m_wait[c] + 1;
          end
        end else if (m_serv[c] != 0) begin
          if (wk == 0) begin
            m_serv[c] = 0;
            m_hold[c] = HO;
          end
        end else if (m_hold[c] > 0) begin
          if (tick) m_hold[c] = m_hold[c] - 1;
        end else if (press != 0) begin
          m_pend[c] = 1;
          m_wait[c] = 0;
        end
        m_rose[c] = 0;
        if (synced != m_lvl[c]) begin
          m_run[c] = m_run[c] + 1;
          if (m_run[c] == DB) begin
            m_lvl[c]  = synced;
            m_run[c]  = 0;
            m_rose[c] = synced;
          end
        end else begin
          m_run[c] = 0;
        end
        m_raw2[c] = m_raw1[c];  m_raw1[c] = raw_now[c];
        m_walk2[c] = m_walk1[c]; m_walk1[c] = walk_now[c];
      end
      exp_q.push_back({m_pend[0] != 0, m_pend[1] != 0,
                       (m_pend[0] != 0) && (m_wait[0] >= MW),
                       (m_pend[1] != 0) && (m_wait[1] >= MW)});
    end
  end

  logic [3:0] exp_v;
  always @(negedge clk) begin
    if (reset_n && exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      vectors++;
      if ({nreq, wreq, nurg, wurg} !== exp_v) begin
        miscompares++;
        $display("FAIL outputs {nreq,wreq,nurg,wurg} t=%0t got %b want %b",
                 $time, {nreq, wreq, nurg, wurg}, exp_v);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      tick = (tcnt == TICK_PERIOD - 1);
      tcnt = (tcnt + 1) % TICK_PERIOD;
    end
  endtask

  task automatic check1(input string name, input logic got, input logic want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got %b want %b", name, got, want);
    end
  endtask

  int edges;

  initial begin
    step(3);
    reset_n = 1'b1;
    step(3);

    // Glitch of three samples, then a held press with measured latency.
    nb = 1'b0; step(3); nb = 1'b1; step(10);
    tick = 1'b0;
    nb = 1'b0;
    edges = 0;
    while (edges < 20 && nreq !== 1'b1) begin
      @(posedge clk); #1;
      edges++;
    end
    vectors++;
    if (edges != 7) begin
      miscompares++;
      $display("FAIL press_latency got %0d edges want 7", edges);
    end
    check1("west_req_untouched", wreq, 1'b0);
    step(5);

    // Service, presses during hold-off, then a fresh press.
    nwa = 1'b1; step(6); nwa = 1'b0;
    nb = 1'b1; step(6);
    nb = 1'b0; step(8); nb = 1'b1; step(30);
    nb = 1'b0; step(10); nb = 1'b1; step(10);

    // Leave it unserved into urgent, then serve.
    step(50);
    nwa = 1'b1; step(6); nwa = 1'b0; step(40);

    // Simultaneous presses; serve west only, then north.
    nb = 1'b0; wb = 1'b0; step(10); nb = 1'b1; wb = 1'b1; step(6);
    wwa = 1'b1; step(6); wwa = 1'b0; step(30);
    check1("nrth_req_after_west_served", nreq, 1'b1);
    nwa = 1'b1; step(6); nwa = 1'b0; step(40);

    // Walk light with no request, then an immediate west press.
    wwa = 1'b1; step(4); wwa = 1'b0;
    wb = 1'b0; step(10); wb = 1'b1; step(6);

    // Asynchronous reset while north is pending.
    nb = 1'b0; step(10); nb = 1'b1; step(3);
    check1("nrth_req_before_reset", nreq, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check1("nrth_req_async_reset", nreq, 1'b0);
    check1("west_req_async_reset", wreq, 1'b0);
    check1("nrth_urg_async_reset", nurg, 1'b0);
    step(2); reset_n = 1'b1; step(5);

    // Randomised segments, with occasional reset pulses.
    repeat (400) begin
      if ($urandom_range(0, 99) == 0) begin
        reset_n = 1'b0; step(1); reset_n = 1'b1;
      end
      nb  = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      wb  = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      nwa = ($urandom_range(0, 3) == 0);
      wwa = ($urandom_range(0, 3) == 0);
      step($urandom_range(1, 12));
    end
    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
